// File: rtl/test_status_collector.sv
// Test status collector: gathers per-agent done/fail pulses into a
// single PASS/FAIL verdict with settle window and watchdog.
module test_status_collector #(
  parameter int N_AGENTS      = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear,
  input  logic [CNT_W-1:0]      timeout_cycles,
  input  logic [N_AGENTS-1:0]   agent_done,
  input  logic [N_AGENTS-1:0]   agent_fail,
  input  logic [8*N_AGENTS-1:0] agent_code,
  output logic                  success,
  output logic                  failure,
  output logic                  busy,
  output logic [1:0]            fail_reason,
  output logic [3:0]            fail_agent,
  output logic [7:0]            fail_code,
  output logic [CNT_W-1:0]      cycle_count
);

  typedef enum logic [2:0] {
    IDLE, RUN, SETTLE, PASS, FAIL
  } state_t;

  localparam logic [1:0] R_NONE = 2'b00;
  localparam logic [1:0] R_FAIL = 2'b01;
  localparam logic [1:0] R_TMO  = 2'b10;
  localparam logic [1:0] R_DUP  = 2'b11;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [N_AGENTS-1:0] mask_q, mask_d;
  logic [7:0]          settle_q, settle_d;
  logic [CNT_W-1:0]    limit_q, limit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          reason_q, reason_d;
  logic [3:0]          agent_q, agent_d;
  logic [7:0]          code_q, code_d;

  logic [3:0] f_idx, d_idx;
  logic [7:0] f_code;
  logic       fail_any, dup_any, all_done, tmo_hit;

  // Lowest-index failing and duplicate-done agents
  always_comb begin
    f_idx  = '0;
    f_code = '0;
    d_idx  = '0;
    for (int i = N_AGENTS - 1; i >= 0; i--) begin
      if (agent_fail[i]) begin
        f_idx  = 4'(i);
        f_code = agent_code[8*i +: 8];
      end
      if (agent_done[i] && mask_q[i]) begin
        d_idx = 4'(i);
      end
    end
  end

  assign fail_any = |agent_fail;
  assign dup_any  = |(agent_done & mask_q);
  assign all_done = &(mask_q | agent_done);
  assign tmo_hit  = (limit_q != '0) &&
                    (cnt_q == limit_q - CNT_W'(1));

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    settle_d = settle_q;
    limit_d  = limit_q;
    cnt_d    = cnt_q;
    reason_d = reason_q;
    agent_d  = agent_q;
    code_d   = code_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          mask_d   = '0;
          settle_d = '0;
          cnt_d    = '0;
          limit_d  = timeout_cycles;
        end
      end
      RUN, SETTLE: begin
        cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        mask_d = mask_q | agent_done;
        if (fail_any) begin
          state_d  = FAIL;
          reason_d = R_FAIL;
          agent_d  = f_idx;
          code_d   = f_code;
        end else if (dup_any) begin
          state_d  = FAIL;
          reason_d = R_DUP;
          agent_d  = d_idx;
          code_d   = '0;
        end else if (tmo_hit) begin
          state_d  = FAIL;
          reason_d = R_TMO;
          agent_d  = '0;
          code_d   = '0;
        end else if (state_q == RUN) begin
          if (all_done) begin
            state_d  = SETTLE;
            settle_d = '0;
          end
        end else if (settle_q == SETTLE_LAST) begin
          state_d = PASS;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      PASS, FAIL: begin
        if (clear) begin
          state_d  = IDLE;
          reason_d = R_NONE;
          agent_d  = '0;
          code_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      settle_q <= '0;
      limit_q  <= '0;
      cnt_q    <= '0;
      reason_q <= R_NONE;
      agent_q  <= '0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      settle_q <= settle_d;
      limit_q  <= limit_d;
      cnt_q    <= cnt_d;
      reason_q <= reason_d;
      agent_q  <= agent_d;
      code_q   <= code_d;
    end
  end

  assign success     = (state_q == PASS);
  assign failure     = (state_q == FAIL);
  assign busy        = (state_q == RUN) || (state_q == SETTLE);
  assign fail_reason = reason_q;
  assign fail_agent  = agent_q;
  assign fail_code   = code_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_test_status_collector.sv
// Directed bench for test_status_collector: vector table plus
// hand-written multi-cycle scenarios.
module tb_test_status_collector;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        clear;
  logic [31:0] tmo;
  logic [3:0]  done;
  logic [3:0]  fail;
  logic [31:0] code;
  logic        success;
  logic        failure;
  logic        busy;
  logic [1:0]  fail_reason;
  logic [3:0]  fail_agent;
  logic [7:0]  fail_code;
  logic [31:0] cycle_count;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  test_status_collector #(
    .N_AGENTS(4),
    .SETTLE_CYCLES(16),
    .CNT_W(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .clear(clear),
    .timeout_cycles(tmo),
    .agent_done(done),
    .agent_fail(fail),
    .agent_code(code),
    .success(success),
    .failure(failure),
    .busy(busy),
    .fail_reason(fail_reason),
    .fail_agent(fail_agent),
    .fail_code(fail_code),
    .cycle_count(cycle_count)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic        clr;
    logic [31:0] tmo;
    logic [3:0]  dn;
    logic [3:0]  fl;
    logic [31:0] cd;
    logic        s;
    logic        f;
    logic        b;
    logic [1:0]  r;
    logic [3:0]  a;
    logic [7:0]  c;
    logic [31:0] n;
  } vec_t;

  vec_t vecs [17];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {15'd0, success, failure, busy, fail_reason,
            fail_agent, fail_code, cycle_count};
  endfunction

  function automatic logic [63:0] pack(input logic s, input logic f,
                                       input logic b,
                                       input logic [1:0] r,
                                       input logic [3:0] a,
                                       input logic [7:0] c,
                                       input logic [31:0] n);
    return {15'd0, s, f, b, r, a, c, n};
  endfunction

  task automatic idle_inputs();
    start = 0;
    clear = 0;
    done  = 0;
    fail  = 0;
    code  = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    tick();
    clear = 0;
    chk("clear_state", outs(),
        pack(0, 0, 0, 2'd0, 4'd0, 8'd0, cycle_count));
  endtask

  // All four agents done on cycles 5..8, optional failure on 12
  task automatic run_seq(input bit inject);
    bit early = 0;
    start = 1;
    tmo   = 1000;
    tick();
    start = 0;
    for (int t = 1; t <= 24; t++) begin
      done = 0;
      fail = 0;
      code = 0;
      if (t >= 5 && t <= 8) done = 4'(1 << (t - 5));
      if (inject && t == 12) begin
        fail = 4'b0100;
        code = 32'h00A5_0000;
      end
      tick();
      idle_inputs();
      if (success && (inject || t < 24)) early = 1;
      if (!inject && t == 8) chk("settle_busy", busy, 1);
      if (inject && t == 12)
        chk("settle_fail", outs(),
            pack(0, 1, 0, 2'd1, 4'd2, 8'hA5, 32'd12));
    end
    chk("no_early_success", early, 0);
    if (inject)
      chk("fail_hold", outs(),
          pack(0, 1, 0, 2'd1, 4'd2, 8'hA5, 32'd12));
    else
      chk("pass", outs(),
          pack(1, 0, 0, 2'd0, 4'd0, 8'd0, 32'd24));
  endtask

  initial begin
    reset = 0;
    tmo   = 0;
    idle_inputs();

    vecs[0]  = '{0,0,0,0,4'h0,4'h0,32'h0, 0,0,0,2'd0,4'd0,8'h00,0};
    vecs[1]  = '{0,1,0,0,4'h0,4'h0,32'h0, 0,0,0,2'd0,4'd0,8'h00,0};
    vecs[2]  = '{1,1,0,0,4'h0,4'h0,32'h0, 0,0,1,2'd0,4'd0,8'h00,0};
    vecs[3]  = '{1,0,0,0,4'h1,4'h0,32'h0, 0,0,1,2'd0,4'd0,8'h00,1};
    vecs[4]  = '{1,0,0,0,4'h1,4'h0,32'h0, 0,1,0,2'd3,4'd0,8'h00,2};
    vecs[5]  = '{1,1,0,0,4'hF,4'hF,32'hFFFF_FFFF,
                 0,1,0,2'd3,4'd0,8'h00,2};
    vecs[6]  = '{1,0,1,0,4'h0,4'h0,32'h0, 0,0,0,2'd0,4'd0,8'h00,2};
    vecs[7]  = '{1,0,0,0,4'hF,4'hF,32'hFFFF_FFFF,
                 0,0,0,2'd0,4'd0,8'h00,2};
    vecs[8]  = '{1,1,0,0,4'h0,4'h0,32'h0, 0,0,1,2'd0,4'd0,8'h00,0};
    vecs[9]  = '{1,0,1,0,4'h2,4'h0,32'h0, 0,0,1,2'd0,4'd0,8'h00,1};
    vecs[10] = '{1,0,0,0,4'h3,4'hC,32'h335A_0000,
                 0,1,0,2'd1,4'd2,8'h5A,2};
    vecs[11] = '{1,0,1,0,4'h0,4'h0,32'h0, 0,0,0,2'd0,4'd0,8'h00,2};
    vecs[12] = '{1,1,0,3,4'h0,4'h0,32'h0, 0,0,1,2'd0,4'd0,8'h00,0};
    vecs[13] = '{1,0,0,0,4'h0,4'h0,32'h0, 0,0,1,2'd0,4'd0,8'h00,1};
    vecs[14] = '{1,0,0,0,4'h0,4'h0,32'h0, 0,0,1,2'd0,4'd0,8'h00,2};
    vecs[15] = '{1,0,0,0,4'h0,4'h0,32'h0, 0,1,0,2'd2,4'd0,8'h00,3};
    vecs[16] = '{1,0,1,0,4'h0,4'h0,32'h0, 0,0,0,2'd0,4'd0,8'h00,3};

    tick();
    for (int k = 0; k < 17; k++) begin
      reset = vecs[k].rst;
      start = vecs[k].st;
      clear = vecs[k].clr;
      tmo   = vecs[k].tmo;
      done  = vecs[k].dn;
      fail  = vecs[k].fl;
      code  = vecs[k].cd;
      tick();
      chk($sformatf("vec%0d", k), outs(),
          pack(vecs[k].s, vecs[k].f, vecs[k].b, vecs[k].r,
               vecs[k].a, vecs[k].c, vecs[k].n));
    end
    idle_inputs();

    // Normal pass, then failure during settle
    run_seq(0);
    do_clear();
    run_seq(1);
    do_clear();

    // Watchdog with agent 3 silent
    start = 1;
    tmo   = 50;
    tick();
    start = 0;
    for (int t = 1; t <= 50; t++) begin
      done = 0;
      if (t >= 2 && t <= 4) done = 4'(1 << (t - 2));
      tick();
      done = 0;
      if (t == 49) begin
        chk("tmo_before", failure, 0);
        chk("tmo_cnt49", cycle_count, 49);
      end
    end
    chk("timeout", outs(),
        pack(0, 1, 0, 2'd2, 4'd0, 8'd0, 32'd50));
    do_clear();

    // Agent fail coincident with the final done
    start = 1;
    tmo   = 0;
    tick();
    start = 0;
    for (int t = 1; t <= 5; t++) begin
      done = 0;
      fail = 0;
      code = 0;
      if (t >= 2 && t <= 4) done = 4'(1 << (t - 2));
      if (t == 5) begin
        done = 4'b1000;
        fail = 4'b1010;
        code = 32'h3300_1100;
      end
      tick();
    end
    idle_inputs();
    chk("fail_vs_done", outs(),
        pack(0, 1, 0, 2'd1, 4'd1, 8'h11, 32'd5));
    do_clear();

    // Reset in the middle of settle, then a fresh passing run
    start = 1;
    tick();
    start = 0;
    done  = 4'hF;
    tick();
    done  = 0;
    chk("in_settle", busy, 1);
    tick();
    tick();
    reset = 0;
    tick();
    chk("mid_reset", outs(),
        pack(0, 0, 0, 2'd0, 4'd0, 8'd0, 32'd0));
    reset = 1;
    run_seq(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/test_status_collector.md
TEST_STATUS_COLLECTOR -- requirements
Module: test_status_collector

Interface
REQ-001 SHALL have parameter N_AGENTS, default 4: number of reporting test agents, range 1..16.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16: quiet cycles required after all agents are done, range 1..255.
REQ-003 SHALL have parameter CNT_W, default 32: width of the cycle counter and of timeout_cycles.
REQ-004 SHALL have port clock, input, 1 bit: clock.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: arms the test; sampled only in IDLE.
REQ-007 SHALL have port clear, input, 1 bit: returns PASS/FAIL to IDLE.
REQ-008 SHALL have port timeout_cycles, input, CNT_W bits: watchdog limit; 0 disables the watchdog; sampled on start.
REQ-009 SHALL have port agent_done, input, N_AGENTS bits: one-cycle per-agent completion pulses.
REQ-010 SHALL have port agent_fail, input, N_AGENTS bits: one-cycle per-agent failure pulses.
REQ-011 SHALL have port agent_code, input, 8*N_AGENTS bits: per-agent failure code; agent i uses bits [8i+7:8i], valid with agent_fail[i].
REQ-012 SHALL have port success, output, 1 bit: level, high in PASS.
REQ-013 SHALL have port failure, output, 1 bit: level, high in FAIL.
REQ-014 SHALL have port busy, output, 1 bit: high in RUN or SETTLE.
REQ-015 SHALL have port fail_reason, output, 2 bits: 00 none, 01 agent failure, 10 timeout, 11 duplicate done.
REQ-016 SHALL have port fail_agent, output, 4 bits: index of the offending agent; 0 for a timeout.
REQ-017 SHALL have port fail_code, output, 8 bits: captured agent_code; 0 unless fail_reason=01.
REQ-018 SHALL have port cycle_count, output, CNT_W bits: cycles elapsed since start; holds in PASS/FAIL.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, SETTLE, PASS, FAIL, all registered.
REQ-020 IDLE: on start=1, SHALL go to RUN next cycle, clear done_mask and cycle_count, and latch timeout_cycles.
REQ-021 SHALL ignore start in any state other than IDLE.
REQ-022 RUN: SHALL OR agent_done into done_mask each cycle.
REQ-023 RUN: when done_mask|agent_done is all ones, SHALL go to SETTLE with settle counter = 0.
REQ-024 RUN/SETTLE: agent_done[i] while done_mask[i]=1 SHALL go to FAIL with fail_reason=11 and fail_agent=i.
REQ-025 RUN/SETTLE: any agent_fail bit SHALL go to FAIL with fail_reason=01; fail_agent and fail_code come from the lowest set index.
REQ-026 SETTLE: SHALL increment the settle counter each cycle and go to PASS when it reaches SETTLE_CYCLES-1 with no fault that cycle.
REQ-027 cycle_count SHALL increment once per cycle in RUN and SETTLE, and saturate at all ones.
REQ-028 Watchdog: if the latched limit is nonzero and cycle_count equals limit-1 in RUN/SETTLE with no other fault, SHALL go to FAIL with fail_reason=10.
REQ-029 Same-cycle priority, highest first: agent fail (01) > duplicate done (11) > timeout (10) > all-done/settle completion.
REQ-030 PASS and FAIL SHALL be terminal: agent inputs are ignored, and fail fields and cycle_count hold.
REQ-031 clear=1 in PASS/FAIL SHALL go to IDLE next cycle and zero fail_reason, fail_agent and fail_code; clear is ignored elsewhere.
REQ-032 Agent inputs in IDLE SHALL be ignored.
REQ-033 All outputs SHALL be registered state decodes or registers, with no combinational input-to-output path.

Reset
REQ-034 reset=0 at a clock edge SHALL force IDLE from any state, including mid-RUN/SETTLE.
REQ-035 On reset, SHALL zero done_mask, settle counter and latched limit, and drive success=0, failure=0, busy=0, fail_reason=00, fail_agent=0, fail_code=0, cycle_count=0.
REQ-036 start asserted in the same cycle as reset=0 SHALL be ignored.

Verification
REQ-037 N=4, timeout=1000: start, pulse done 0..3 on cycles 5,6,7,8 -> SETTLE on cycle 8; success=1 16 cycles later; cycle_count=24.
REQ-038 Same run, agent_fail[2] with code 8'hA5 on cycle 12, during SETTLE -> failure=1, fail_reason=01, fail_agent=2, fail_code=A5, success never 1.
REQ-039 timeout=50, agents 0..2 done, agent 3 silent -> failure one cycle after cycle_count=49, fail_reason=10, cycle_count=50.
REQ-040 agent_fail=4'b1010 and the final done in the same cycle -> FAIL, fail_agent=1, fail_reason=01.
REQ-041 agent_done[0] pulsed twice in RUN -> FAIL, fail_reason=11, fail_agent=0; then clear -> IDLE with all fail fields zero.
REQ-042 reset=0 mid-SETTLE -> next cycle IDLE with all outputs at reset values; a fresh start then passes normally.
